game_controller: RTL and testbench
==================================

GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 1_000_000, giving the debounce stable-time in clk cycles.
REQ-002 The block SHALL have parameter CAR_X_MIN, default 200, giving the leftmost car x position in pixels.
REQ-003 The block SHALL have parameter CAR_X_MAX, default 420, giving the rightmost car x position in pixels.
REQ-004 The block SHALL have parameter CAR_X_HOME, default 310, giving the car x position at game start.
REQ-005 The block SHALL have parameter STEP, default 4, giving the car x change in pixels per frame.
REQ-006 The block SHALL have parameter SPEED, default 3, giving the road scroll in lines per frame.
REQ-007 The block SHALL have parameter CRASH_FRAMES, default 120, giving the length of the crash animation in frames.
REQ-008 The block SHALL have port clk, input, 1 bit: the single system clock.
REQ-009 The block SHALL have port btnC, input, 1 bit: reset, asynchronous and active-high.
REQ-010 The block SHALL have port btnL, input, 1 bit: raw, asynchronous left button.
REQ-011 The block SHALL have port btnR, input, 1 bit: raw, asynchronous right button.
REQ-012 The block SHALL have port VS, input, 1 bit: VGA vertical sync, active-low, from the display timing.
REQ-013 The block SHALL have port collision, input, 1 bit: per-pixel car/obstacle overlap flag from the sprite datapath.
REQ-014 The block SHALL have port car_x, output, 10 bits: car sprite left x.
REQ-015 The block SHALL have port scroll_y, output, 9 bits: road scroll offset, range 0..479.
REQ-016 The block SHALL have port game_state, output, 2 bits: current FSM state.
REQ-017 The block SHALL have port score, output, 16 bits: frames survived.

Function
REQ-018 btnL and btnR SHALL each pass through a 2-flop synchronizer and then a debouncer; the debounced level changes only after the synchronized input has been stable for DEB_CYCLES consecutive cycles.
REQ-019 A frame tick SHALL be a one-cycle pulse on the rising edge of the synchronized VS (end of the sync pulse); all position, scroll, score and crash-count updates occur only on frame tick cycles.
REQ-020 A collision latch SHALL set on any cycle with collision=1 in RUN, and SHALL clear on every frame tick after it has been evaluated.
REQ-021 FSM states SHALL be IDLE=0, RUN=1, CRASH=2 and OVER=3.
REQ-022 In IDLE, car_x=CAR_X_HOME, scroll_y=0 and score=0; a debounced rising edge on L or R SHALL transition to RUN.
REQ-023 In RUN on a frame tick with the latch clear: L-only SHALL move car_x down by STEP, clamped to CAR_X_MIN; R-only SHALL move it up by STEP, clamped to CAR_X_MAX; both or neither SHALL hold car_x.
REQ-024 In RUN on a frame tick with the latch clear: scroll_y SHALL become (scroll_y+SPEED) mod 480, and score SHALL increment, saturating at 0xFFFF.
REQ-025 In RUN on a frame tick with the latch set, the block SHALL go to CRASH with no car_x, scroll_y or score update that frame, and SHALL zero the crash counter.
REQ-026 In CRASH, all outputs SHALL hold; the crash counter SHALL increment per tick, and the block SHALL go to OVER on the tick where the count reaches CRASH_FRAMES-1.
REQ-027 In OVER, outputs SHALL hold; a debounced rising edge on L or R SHALL go to IDLE.
REQ-028 A debounced button edge coinciding with a frame tick SHALL be honoured for the state transition only; movement begins on the next tick.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 btnC=1 SHALL asynchronously force game_state=IDLE, car_x=CAR_X_HOME, scroll_y=0, score=0, clear the latch, the crash counter, the synchronizers and the debouncers (debounced level 0); reset mid-RUN or mid-CRASH SHALL behave identically.

Structure
REQ-031 State encodings, and the 480-line screen height constant, SHALL live in the shared package game_pkg.
REQ-032 The debouncer SHALL be sub-module btn_debounce (synchronizer + counter), instantiated twice.

Verification (DEB_CYCLES=4, CRASH_FRAMES=3; VS driven as frame pulses)
REQ-033 Reset, then hold btnR 10 cycles, then release -> game_state 0->1; car_x=310 until the first tick.
REQ-034 RUN with btnR held for 40 ticks -> car_x 314,318,... reaching 420 and staying at 420; scroll_y wraps 477->0 (SPEED=3).
REQ-035 RUN with btnL and btnR both held for 5 ticks -> car_x unchanged; score increments by 5.
REQ-036 Pulse collision for 1 cycle mid-frame -> at the next tick game_state=2 with score frozen; 3 ticks later game_state=3; a btnL press returns game_state to 0 with score=0.
REQ-037 Assert btnC asynchronously mid-RUN (between clk edges) -> outputs reach their reset values immediately; a glitch on btnL shorter than 4 cycles -> no state change.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the road game controller: FSM state encodings
// and the visible screen height used for scroll wrapping.
package game_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CRASH = 2'd2,
    ST_OVER  = 2'd3
  } game_state_t;

  localparam int SCREEN_H = 480;
endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stable-time debouncer; the output level
// flips only after the synchronized input has disagreed with it for DEB_CYCLES cycles.
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level
);
  localparam int CNT_W = $clog2(DEB_CYCLES) + 1;

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync  <= 2'b00;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      // Any cycle where the input agrees with the current level restarts the count.
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
endmodule

// File: rtl/game_controller.sv
// Road game controller: debounced steering buttons, VS-derived frame tick,
// collision latch and an IDLE/RUN/CRASH/OVER game FSM with registered outputs.
module game_controller
  import game_pkg::*;
#(
  parameter int DEB_CYCLES   = 1_000_000,
  parameter int CAR_X_MIN    = 200,
  parameter int CAR_X_MAX    = 420,
  parameter int CAR_X_HOME   = 310,
  parameter int STEP         = 4,
  parameter int SPEED        = 3,
  parameter int CRASH_FRAMES = 120
) (
  input  logic        clk,
  input  logic        btnC,
  input  logic        btnL,
  input  logic        btnR,
  input  logic        VS,
  input  logic        collision,
  output logic [9:0]  car_x,
  output logic [8:0]  scroll_y,
  output logic [1:0]  game_state,
  output logic [15:0] score
);
  localparam int CW = $clog2(CRASH_FRAMES) + 1;

  logic        w_l_db, w_r_db, w_btn_rise, w_tick;
  logic        r_l_prev, r_r_prev;
  logic [1:0]  r_vs_sync;
  logic        r_vs_prev;
  logic        r_coll;
  logic [CW-1:0] r_crash_cnt;
  game_state_t r_state, w_state_next;
  logic [9:0]  r_car_x, w_x_next;
  logic [8:0]  r_scroll, w_scroll_next;
  logic [9:0]  w_scroll_sum;
  logic [15:0] r_score;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_l (
    .i_clk(clk), .i_rst(btnC), .i_btn(btnL), .o_level(w_l_db)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_r (
    .i_clk(clk), .i_rst(btnC), .i_btn(btnR), .o_level(w_r_db)
  );

  assign w_btn_rise = (w_l_db & ~r_l_prev) | (w_r_db & ~r_r_prev);
  // VS is active-low, so the rising edge marks the end of the sync pulse.
  assign w_tick     = r_vs_sync[1] & ~r_vs_prev;

  always_ff @(posedge clk or posedge btnC) begin
    if (btnC) begin
      r_l_prev  <= 1'b0;
      r_r_prev  <= 1'b0;
      r_vs_sync <= 2'b11;
      r_vs_prev <= 1'b1;
    end else begin
      r_l_prev  <= w_l_db;
      r_r_prev  <= w_r_db;
      r_vs_sync <= {r_vs_sync[0], VS};
      r_vs_prev <= r_vs_sync[1];
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_btn_rise) w_state_next = ST_RUN;
      ST_RUN:   if (w_tick && r_coll) w_state_next = ST_CRASH;
      ST_CRASH: if (w_tick && r_crash_cnt == CW'(CRASH_FRAMES - 1)) w_state_next = ST_OVER;
      ST_OVER:  if (w_btn_rise) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge btnC) begin
    if (btnC) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_x_next = r_car_x;
    if (w_l_db && !w_r_db)
      w_x_next = (r_car_x < 10'(CAR_X_MIN + STEP)) ? 10'(CAR_X_MIN) : r_car_x - 10'(STEP);
    else if (w_r_db && !w_l_db)
      w_x_next = (({1'b0, r_car_x} + 11'(STEP)) > 11'(CAR_X_MAX)) ? 10'(CAR_X_MAX)
                                                                 : r_car_x + 10'(STEP);
    w_scroll_sum  = {1'b0, r_scroll} + 10'(SPEED);
    w_scroll_next = (w_scroll_sum >= 10'(SCREEN_H)) ? 9'(w_scroll_sum - 10'(SCREEN_H))
                                                    : w_scroll_sum[8:0];
  end

  always_ff @(posedge clk or posedge btnC) begin
    if (btnC) begin
      r_car_x     <= 10'(CAR_X_HOME);
      r_scroll    <= '0;
      r_score     <= '0;
      r_coll      <= 1'b0;
      r_crash_cnt <= '0;
    end else begin
      // The latch is consumed by the FSM on the tick, then cleared for the next frame.
      if (w_tick)                             r_coll <= 1'b0;
      else if (r_state == ST_RUN && collision) r_coll <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          r_car_x  <= 10'(CAR_X_HOME);
          r_scroll <= '0;
          r_score  <= '0;
        end
        ST_RUN: begin
          if (w_tick && r_coll) begin
            r_crash_cnt <= '0;
          end else if (w_tick) begin
            r_car_x  <= w_x_next;
            r_scroll <= w_scroll_next;
            if (r_score != 16'hFFFF) r_score <= r_score + 1'b1;
          end
        end
        ST_CRASH: if (w_tick) r_crash_cnt <= r_crash_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign car_x      = r_car_x;
  assign scroll_y   = r_scroll;
  assign game_state = r_state;
  assign score      = r_score;
endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller with short debounce and crash lengths;
// expected values come from hand arithmetic and a tiny position/scroll/score model.
module tb_game_controller;
  logic        clk, btnC, btnL, btnR, VS, collision;
  logic [9:0]  car_x;
  logic [8:0]  scroll_y;
  logic [1:0]  game_state;
  logic [15:0] score;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_x, exp_scroll, exp_score;

  game_controller #(
    .DEB_CYCLES(4), .CAR_X_MIN(200), .CAR_X_MAX(420), .CAR_X_HOME(310),
    .STEP(4), .SPEED(3), .CRASH_FRAMES(3)
  ) dut (
    .clk(clk), .btnC(btnC), .btnL(btnL), .btnR(btnR), .VS(VS),
    .collision(collision), .car_x(car_x), .scroll_y(scroll_y),
    .game_state(game_state), .score(score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One VGA frame: VS low for a few cycles, then high; the tick follows the rise.
  task automatic frame_tick();
    @(negedge clk) VS = 1'b0;
    wait_cycles(2);
    VS = 1'b1;
    wait_cycles(6);
  endtask

  task automatic check_outputs(input string name, input int st, input int x,
                               input int sc, input int scr);
    n_tests++;
    if (game_state !== 2'(st) || car_x !== 10'(x) || scroll_y !== 9'(sc) || score !== 16'(scr)) begin
      n_fail++;
      $display("FAIL %s: got state=%0d x=%0d scroll=%0d score=%0d, want state=%0d x=%0d scroll=%0d score=%0d",
               name, game_state, car_x, scroll_y, score, st, x, sc, scr);
    end
  endtask

  task automatic test_reset();
    btnC = 1'b1; btnL = 1'b0; btnR = 1'b0; VS = 1'b1; collision = 1'b0;
    wait_cycles(3);
    check_outputs("reset_hold", 0, 310, 0, 0);
    btnC = 1'b0;
    wait_cycles(3);
    check_outputs("after_reset", 0, 310, 0, 0);
  endtask

  task automatic test_start();
    btnR = 1'b1;
    wait_cycles(10);
    btnR = 1'b0;
    wait_cycles(2);
    check_outputs("start_run", 1, 310, 0, 0);
    wait_cycles(10);
    check_outputs("run_before_tick", 1, 310, 0, 0);
    exp_x = 310; exp_scroll = 0; exp_score = 0;
  endtask

  task automatic model_tick(input bit l, input bit r);
    if (l && !r)      exp_x = (exp_x < 204) ? 200 : exp_x - 4;
    else if (r && !l) exp_x = (exp_x + 4 > 420) ? 420 : exp_x + 4;
    exp_scroll = (exp_scroll + 3) % 480;
    exp_score  = exp_score + 1;
  endtask

  task automatic test_move_right();
    btnR = 1'b1;
    wait_cycles(10);
    for (int i = 0; i < 40; i++) begin
      frame_tick();
      model_tick(1'b0, 1'b1);
      check_outputs("move_right", 1, exp_x, exp_scroll, exp_score);
    end
    btnR = 1'b0;
    wait_cycles(10);
    // Coast until scroll wraps past 477 back to 0.
    for (int i = 0; i < 125; i++) begin
      frame_tick();
      model_tick(1'b0, 1'b0);
      if (exp_scroll < 6) check_outputs("scroll_wrap", 1, exp_x, exp_scroll, exp_score);
    end
    check_outputs("coast_end", 1, 420, 15, 165);
  endtask

  task automatic test_both_held();
    btnL = 1'b1; btnR = 1'b1;
    wait_cycles(10);
    for (int i = 0; i < 5; i++) begin
      frame_tick();
      model_tick(1'b1, 1'b1);
    end
    check_outputs("both_held", 1, 420, exp_scroll, 170);
    btnL = 1'b0; btnR = 1'b0;
    wait_cycles(10);
  endtask

  task automatic test_move_left();
    btnL = 1'b1;
    wait_cycles(10);
    for (int i = 0; i < 60; i++) begin
      frame_tick();
      model_tick(1'b1, 1'b0);
      check_outputs("move_left", 1, exp_x, exp_scroll, exp_score);
    end
    check_outputs("left_clamp", 1, 200, exp_scroll, exp_score);
    btnL = 1'b0;
    wait_cycles(10);
  endtask

  task automatic test_collision();
    wait_cycles(2);
    collision = 1'b1;
    @(negedge clk) collision = 1'b0;
    wait_cycles(2);
    check_outputs("latched_no_tick_yet", 1, exp_x, exp_scroll, exp_score);
    frame_tick();
    check_outputs("crash_enter", 2, exp_x, exp_scroll, exp_score);
    frame_tick();
    check_outputs("crash_t1", 2, exp_x, exp_scroll, exp_score);
    frame_tick();
    check_outputs("crash_t2", 2, exp_x, exp_scroll, exp_score);
    frame_tick();
    check_outputs("over", 3, exp_x, exp_scroll, exp_score);
    frame_tick();
    check_outputs("over_hold", 3, exp_x, exp_scroll, exp_score);
    btnL = 1'b1;
    wait_cycles(10);
    btnL = 1'b0;
    wait_cycles(4);
    check_outputs("back_to_idle", 0, 310, 0, 0);
    wait_cycles(10);
  endtask

  task automatic test_async_reset();
    btnR = 1'b1;
    wait_cycles(10);
    btnR = 1'b0;
    wait_cycles(10);
    frame_tick();
    frame_tick();
    check_outputs("rerun", 1, 310, 6, 2);
    @(posedge clk);
    #3 btnC = 1'b1;
    #1 check_outputs("async_reset", 0, 310, 0, 0);
    wait_cycles(2);
    btnC = 1'b0;
    wait_cycles(3);
    btnL = 1'b1;
    wait_cycles(3);
    btnL = 1'b0;
    wait_cycles(20);
    check_outputs("glitch_ignored", 0, 310, 0, 0);
  endtask

  initial begin
    test_reset();
    test_start();
    test_move_right();
    test_both_held();
    test_move_left();
    test_collision();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
